countdown_timer16: RTL and testbench
====================================

// Module: countdown_timer16
// PURPOSE
//  Loadable 16-bit down-counting timer: the decrementing counterpart of the inc16 incrementer.
//  Host loads a count, starts it, and gets a 1-cycle done pulse plus a sticky flag at zero.
//  Sits beside the PC/register datapath as the Hack CPU's delay and timeout source.
//  Decrement arithmetic lives in combinational sub-module dec16.
// PARAMETERS
//  WIDTH        16  counter / load-value width in bits
//  AUTO_RELOAD  0   1 = reload from reload register at terminal count and keep running
// PORTS
//  clk       in   1      single clock, rising edge
//  reset     in   1      synchronous, active-high reset
//  load      in   1      capture load_val into count and reload register
//  load_val  in   WIDTH  value to load
//  start     in   1      begin counting (IDLE or EXPIRED only)
//  pause     in   1      level; while 1 in RUN, count holds
//  ack       in   1      clears done_flag
//  count     out  WIDTH  current count value
//  busy      out  1      1 while state == RUN
//  done      out  1      1-cycle pulse, registered, on reaching terminal count
//  done_flag out  1      sticky done, cleared by ack
// BEHAVIOUR
//  - Clock/reset: one clock (clk); reset is synchronous and active-high.
//  - All outputs registered. Reset values: count=0, reload=0, state=IDLE,
//    busy=0, done=0, done_flag=0.
//  - Reset mid-operation: all reset values take effect at the next edge. Reset wins over every input.
//  - States:
//    IDLE -> RUN on start when count!=0.
//    IDLE -> EXPIRED on start when count==0; done pulses.
//    RUN -> EXPIRED at terminal count when AUTO_RELOAD=0.
//    EXPIRED -> RUN on start when count!=0.
//    Any state -> IDLE on load.
//  - Priority per edge: reset > load > start > count.
//    load with start in the same cycle: load wins and start is ignored.
//    load during RUN aborts the run: count=load_val, state=IDLE, no done.
//  - start in RUN is ignored.
//  - Start edge: no decrement on the start edge itself.
//    Each later RUN edge with pause=0 sets count = dec16(count).
//    Load N, start sampled at edge E0 -> count==0 and done==1 in the cycle after edge E0+N.
//  - Terminal count, when count==1 and decrementing:
//    AUTO_RELOAD=0: count -> 0, state -> EXPIRED, done=1 for one cycle.
//    AUTO_RELOAD=1: count -> reload, state stays RUN, done=1 for one cycle.
//    AUTO_RELOAD=1 with pause at the terminal edge: hold; no pulse until resumed.
//  - pause=1 in RUN: count, state and busy held. pause is ignored outside RUN.
//  - done_flag is set with done and cleared by ack.
//    If set and ack occur on the same edge, set wins.
//  - Width rule: dec16 is modulo 2^WIDTH (0 -> all-ones).
//    The RUN path never decrements 0, so the counter never wraps.
// STRUCTURE
//  - Shared package timer_pkg:
//    state typedef {IDLE=2'd0, RUN=2'd1, EXPIRED=2'd2}.
//    WIDTH default constant.
//  - Sub-module dec16: combinational out = in - 1, modulo 2^WIDTH.
//    Instantiated once. Unit-testable mirror of inc16.
//  - Top level: state register, count/reload registers, done/done_flag logic.
// TESTING
//  1. Reset during RUN: load 0x0005, start, assert reset after 2 cycles -> next edge
//     count=0, busy=0, done=0, done_flag=0.
//  2. Basic countdown: load 0x000A, start at E0 -> count 9..0 on E1..E10; done=1
//     only after E10; busy falls after E10; done_flag stays 1 until ack.
//  3. Zero and boundary loads:
//     load 0x0000 + start -> done pulse next cycle, no decrement, count=0.
//     load 0xFFFF + start -> done after 65535 RUN edges.
//  4. Priority and pause:
//     load 0x0003 and start in the same cycle -> IDLE, count=3.
//     In RUN, pause 4 cycles -> count frozen, done 4 cycles later.
//     load 0x0007 mid-run -> IDLE, no done.
//  5. AUTO_RELOAD=1 with load 0x0003: done pulses every 3 cycles; count sequence 3,2,1,3,2,1.
//     ack on a pulse edge -> done_flag stays 1.
//  6. dec16 standalone: 0x0000->0xFFFF, 0x000A->0x0009, 0x8000->0x7FFF, 0xAAAA->0xAAA9.

Source files
------------

// File: rtl/timer_pkg.sv
// timer_pkg: shared state encoding and default width for the countdown timer
package timer_pkg;
  localparam int DEF_WIDTH = 16;
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RUN     = 2'd1,
    EXPIRED = 2'd2
  } state_t;
endpackage

// File: rtl/dec16.sv
// dec16: combinational decrement, modulo 2^WIDTH
module dec16 #(
  parameter int WIDTH = 16
) (
  input  logic [WIDTH-1:0] val,
  output logic [WIDTH-1:0] res
);
  assign res = val - WIDTH'(1);
endmodule

// File: rtl/countdown_timer16.sv
// countdown_timer16: loadable down-counting timer with done pulse, sticky flag and optional auto-reload
module countdown_timer16
  import timer_pkg::*;
#(
  parameter int WIDTH       = DEF_WIDTH,
  parameter bit AUTO_RELOAD = 1'b0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             start,
  input  logic             pause,
  input  logic             ack,
  output logic [WIDTH-1:0] count,
  output logic             busy,
  output logic             done,
  output logic             done_flag
);
  state_t           state, state_n;
  logic [WIDTH-1:0] reload, reload_n, count_n, count_dec;
  logic             done_set;
  dec16 #(.WIDTH(WIDTH)) u_dec (
    .val(count),
    .res(count_dec)
  );
  always_comb begin
    state_n  = state;
    count_n  = count;
    reload_n = reload;
    done_set = 1'b0;
    if (load) begin
      count_n  = load_val;
      reload_n = load_val;
      state_n  = IDLE;
    end else if (start && state != RUN) begin
      state_n  = (count == '0) ? EXPIRED : RUN;
      done_set = (count == '0);
    end else if (state == RUN && !pause) begin
      // count==1 is the terminal edge; the RUN path never sees 0
      done_set = (count == WIDTH'(1));
      count_n  = (done_set && AUTO_RELOAD) ? reload : count_dec;
      state_n  = (done_set && !AUTO_RELOAD) ? EXPIRED : RUN;
    end
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      count     <= '0;
      reload    <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      done_flag <= 1'b0;
    end else begin
      state     <= state_n;
      count     <= count_n;
      reload    <= reload_n;
      busy      <= (state_n == RUN);
      done      <= done_set;
      done_flag <= done_set | (done_flag & ~ack);
    end
  end
endmodule

// File: tb/tb_countdown_timer16.sv
// tb_countdown_timer16: directed stimulus against a behavioural timer model, both reload modes plus dec16
module tb_countdown_timer16;
  logic        clk = 1'b0;
  logic        reset = 1'b1, load = 1'b0, start = 1'b0, pause = 1'b0, ack = 1'b0;
  logic [15:0] load_val = '0;
  logic [15:0] count0, count1, dval, dres;
  logic        busy0, busy1, done0, done1, flag0, flag1;
  int          total = 0, bad = 0;
  bit          chk = 1'b0;
  logic [15:0] m_cnt[2], m_rl[2];
  int          m_st[2];
  bit          m_dn[2], m_fl[2];

  always #5 clk = ~clk;

  countdown_timer16 #(.WIDTH(16), .AUTO_RELOAD(1'b0)) dut0 (
    .clk(clk), .reset(reset), .load(load), .load_val(load_val), .start(start),
    .pause(pause), .ack(ack), .count(count0), .busy(busy0), .done(done0), .done_flag(flag0));
  countdown_timer16 #(.WIDTH(16), .AUTO_RELOAD(1'b1)) dut1 (
    .clk(clk), .reset(reset), .load(load), .load_val(load_val), .start(start),
    .pause(pause), .ack(ack), .count(count1), .busy(busy1), .done(done1), .done_flag(flag1));
  dec16 #(.WIDTH(16)) u_dec (.val(dval), .res(dres));

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
    end
  endtask

  // model states: 0 idle, 1 running, 2 expired
  task automatic tick();
    logic [15:0] nc[2], nr[2];
    int          ns[2];
    bit          nd[2], nf[2];
    for (int k = 0; k < 2; k++) begin
      nc[k] = m_cnt[k];
      nr[k] = m_rl[k];
      ns[k] = m_st[k];
      nd[k] = 1'b0;
      if (reset) begin
        nc[k] = 0;
        nr[k] = 0;
        ns[k] = 0;
      end else if (load) begin
        nc[k] = load_val;
        nr[k] = load_val;
        ns[k] = 0;
      end else if (start && m_st[k] != 1) begin
        ns[k] = (m_cnt[k] == 0) ? 2 : 1;
        nd[k] = (m_cnt[k] == 0);
      end else if (m_st[k] == 1 && !pause) begin
        if (m_cnt[k] == 1) begin
          nd[k] = 1'b1;
          nc[k] = (k == 1) ? m_rl[k] : 16'd0;
          ns[k] = (k == 1) ? 1 : 2;
        end else nc[k] = m_cnt[k] - 16'd1;
      end
      nf[k] = reset ? 1'b0 : (nd[k] || (m_fl[k] && !ack));
    end
    @(posedge clk);
    #1;
    for (int k = 0; k < 2; k++) begin
      m_cnt[k] = nc[k];
      m_rl[k]  = nr[k];
      m_st[k]  = ns[k];
      m_dn[k]  = nd[k];
      m_fl[k]  = nf[k];
    end
  endtask

  task automatic ticks(int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  always @(negedge clk) if (chk) begin
    check("count0", count0, m_cnt[0]);
    check("busy0", busy0, m_st[0] == 1);
    check("done0", done0, m_dn[0]);
    check("flag0", flag0, m_fl[0]);
    check("count1", count1, m_cnt[1]);
    check("busy1", busy1, m_st[1] == 1);
    check("done1", done1, m_dn[1]);
    check("flag1", flag1, m_fl[1]);
  end

  initial begin
    logic [15:0] dv[4];
    logic [15:0] de[4];
    for (int k = 0; k < 2; k++) begin
      m_cnt[k] = 0; m_rl[k] = 0; m_st[k] = 0; m_dn[k] = 0; m_fl[k] = 0;
    end
    dval = 16'h0000;
    ticks(2);
    chk = 1'b1;
    reset = 1'b0;
    check("rst_count", count0, 0);
    check("rst_busy", busy0, 0);
    check("rst_done", done0, 0);
    check("rst_flag", flag0, 0);
    // reset during a run
    load = 1'b1; load_val = 16'h0005; tick(); load = 1'b0;
    start = 1'b1; tick(); start = 1'b0;
    ticks(2);
    check("t1_mid_count", count0, 16'h0003);
    reset = 1'b1; tick(); reset = 1'b0;
    check("t1_count", count0, 0);
    check("t1_busy", busy0, 0);
    check("t1_done", done0, 0);
    check("t1_flag", flag0, 0);
    // basic countdown of 10
    load = 1'b1; load_val = 16'h000A; tick(); load = 1'b0;
    start = 1'b1; tick(); start = 1'b0;
    check("t2_e0_count", count0, 16'h000A);
    check("t2_e0_busy", busy0, 1);
    ticks(9);
    check("t2_e9_count", count0, 16'h0001);
    check("t2_e9_done", done0, 0);
    tick();
    check("t2_e10_count", count0, 0);
    check("t2_e10_done", done0, 1);
    check("t2_e10_busy", busy0, 0);
    check("t2_ar_count", count1, 16'h000A);
    tick();
    check("t2_pulse_end", done0, 0);
    check("t2_flag_held", flag0, 1);
    ack = 1'b1; tick(); ack = 1'b0;
    check("t2_flag_ack", flag0, 0);
    // zero load: immediate pulse without decrement
    load = 1'b1; load_val = 16'h0000; tick(); load = 1'b0;
    start = 1'b1; tick(); start = 1'b0;
    check("t3_zero_done", done0, 1);
    check("t3_zero_count", count0, 0);
    check("t3_zero_busy", busy0, 0);
    ack = 1'b1; tick(); ack = 1'b0;
    // full-range load
    load = 1'b1; load_val = 16'hFFFF; tick(); load = 1'b0;
    start = 1'b1; tick(); start = 1'b0;
    ticks(65534);
    check("t3_ffff_pre", count0, 16'h0001);
    check("t3_ffff_predone", done0, 0);
    tick();
    check("t3_ffff_count", count0, 0);
    check("t3_ffff_done", done0, 1);
    check("t3_ffff_reload", count1, 16'hFFFF);
    // load and start together: load wins
    load = 1'b1; start = 1'b1; load_val = 16'h0003; tick(); load = 1'b0; start = 1'b0;
    check("t4_ls_count", count0, 16'h0003);
    check("t4_ls_busy", busy0, 0);
    start = 1'b1; tick(); start = 1'b0;
    tick();
    pause = 1'b1; ticks(4); pause = 1'b0;
    check("t4_pause_count", count0, 16'h0002);
    check("t4_pause_busy", busy0, 1);
    tick();
    check("t4_resume", count0, 16'h0001);
    tick();
    check("t4_done", done0, 1);
    // load mid-run aborts
    load = 1'b1; load_val = 16'h0009; tick(); load = 1'b0;
    start = 1'b1; tick(); start = 1'b0;
    ticks(2);
    load = 1'b1; load_val = 16'h0007; tick(); load = 1'b0;
    check("t4_abort_count", count0, 16'h0007);
    check("t4_abort_busy", busy0, 0);
    check("t4_abort_done", done0, 0);
    ticks(2);
    // auto-reload sequence 3,2,1,3,2,1
    load = 1'b1; load_val = 16'h0003; tick(); load = 1'b0;
    start = 1'b1; tick(); start = 1'b0;
    check("t5_e0", count1, 16'h0003);
    tick(); check("t5_e1", count1, 16'h0002);
    tick(); check("t5_e2", count1, 16'h0001);
    tick(); check("t5_e3", count1, 16'h0003); check("t5_e3_done", done1, 1);
    tick(); check("t5_e4", count1, 16'h0002); check("t5_e4_done", done1, 0);
    tick(); check("t5_e5", count1, 16'h0001);
    ack = 1'b1; tick(); ack = 1'b0;
    check("t5_e6", count1, 16'h0003);
    check("t5_e6_done", done1, 1);
    check("t5_ack_flag", flag1, 1);
    check("t5_busy", busy1, 1);
    ticks(2);
    pause = 1'b1; tick(); pause = 1'b0;
    check("t5_paused", count1, 16'h0001);
    check("t5_paused_done", done1, 0);
    tick();
    check("t5_resumed", count1, 16'h0003);
    check("t5_resumed_done", done1, 1);
    chk = 1'b0;
    // dec16 standalone
    dv = '{16'h0000, 16'h000A, 16'h8000, 16'hAAAA};
    de = '{16'hFFFF, 16'h0009, 16'h7FFF, 16'hAAA9};
    for (int i = 0; i < 4; i++) begin
      dval = dv[i];
      #1;
      check("dec16", dres, de[i]);
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
